// File: rtl/ras_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ras_pkg
//  Description : Shared types and default sizes for the return address stack
//                checkpoint/recovery logic.
//                DEF_STACK_SIZE / DEF_PTR_W : default RAS depth and pointer width
//                DEF_CKPT_DEPTH             : default number of checkpoint slots
//                ras_ckpt_t                 : one snapshot {ptr, top}
//                ras_ckpt_state_e           : controller FSM states
//  Revision    : 1.0 - initial release
// ============================================================================
package ras_pkg;

   localparam int DEF_STACK_SIZE = 8;
   localparam int DEF_PTR_W      = $clog2(DEF_STACK_SIZE);
   localparam int DEF_CKPT_DEPTH = 16;

   typedef struct packed {
      logic [DEF_PTR_W-1:0] ptr;
      logic [31:0]          top;
   } ras_ckpt_t;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RESTORE = 1'b1
   } ras_ckpt_state_e;

endpackage : ras_pkg
`default_nettype wire

// File: rtl/ras_ckpt_mem.sv
`default_nettype none
// ============================================================================
//  Module      : ras_ckpt_mem
//  Description : Checkpoint storage, DEPTH entries of {ptr, top}.
//                Two synchronous write ports, one asynchronous read port.
//                No reset: entry contents are only meaningful once written.
//  Ports       : clock                   - clock
//                wen[1:0]                - per-port write enable
//                waddr[1:0]              - per-port write address
//                wdata_ptr / wdata_top   - per-port write data
//                raddr                   - read address
//                rdata_ptr / rdata_top   - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_ckpt_mem #(
   parameter  int DEPTH = 16,
   parameter  int PTR_W = 3,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic [1:0]            wen,
   input  logic [1:0][AW-1:0]    waddr,
   input  logic [1:0][PTR_W-1:0] wdata_ptr,
   input  logic [1:0][31:0]      wdata_top,
   input  logic [AW-1:0]         raddr,
   output logic [PTR_W-1:0]      rdata_ptr,
   output logic [31:0]           rdata_top
);

   logic [PTR_W-1:0] ptr_mem [DEPTH];
   logic [31:0]      top_mem [DEPTH];

   // The two ports never target the same slot in legal operation; if they
   // did, port 1 would win.
   always_ff @(posedge clock) begin
      for (int i = 0; i < 2; i++) begin
         if (wen[i]) begin
            ptr_mem[waddr[i]] <= wdata_ptr[i];
            top_mem[waddr[i]] <= wdata_top[i];
         end
      end
   end

   assign rdata_ptr = ptr_mem[raddr];
   assign rdata_top = top_mem[raddr];

endmodule : ras_ckpt_mem
`default_nettype wire

// File: rtl/ras_ckpt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ras_ckpt_ctrl
//  Description : Checkpoint and recovery controller for a 2-wide return
//                address stack. Snapshots {ptr, top} per predicted branch,
//                frees them in order at retirement, and on a mispredict
//                squashes younger snapshots and drives a one-cycle RAS repair.
//  Ports       : clock, reset            - clock, synchronous active-high reset
//                alloc_valid/ckpt_ptr/ckpt_top - per-slot snapshot request
//                alloc_ready             - allocation accepted this cycle
//                alloc_tag               - tag per slot (combinational)
//                retire_valid            - in-order frees
//                mispredict_valid/_tag   - branch mispredict and its tag
//                restore_valid/_ptr/_top - RAS repair strobe and data
//                fetch_stall             - fetch must hold
//                free_count              - number of free slots
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_ckpt_ctrl
   import ras_pkg::*;
#(
   parameter  int STACK_SIZE = DEF_STACK_SIZE,
   parameter  int CKPT_DEPTH = DEF_CKPT_DEPTH,
   localparam int PTR_W      = $clog2(STACK_SIZE),
   localparam int TAG_W      = $clog2(CKPT_DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            alloc_valid,
   input  logic [1:0][PTR_W-1:0] ckpt_ptr,
   input  logic [1:0][31:0]      ckpt_top,
   output logic                  alloc_ready,
   output logic [1:0][TAG_W-1:0] alloc_tag,
   input  logic [1:0]            retire_valid,
   input  logic                  mispredict_valid,
   input  logic [TAG_W-1:0]      mispredict_tag,
   output logic                  restore_valid,
   output logic [PTR_W-1:0]      restore_ptr,
   output logic [31:0]           restore_top,
   output logic                  fetch_stall,
   output logic [TAG_W:0]        free_count
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   localparam int            PW          = TAG_W + 1;
   localparam logic [PW-1:0] ALLOC_LIMIT = PW'(CKPT_DEPTH - 2);
   localparam logic [PW-1:0] DEPTH_C     = PW'(CKPT_DEPTH);

   ras_ckpt_state_e state;
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [PW-1:0]   count;

   logic [1:0]       wen;
   logic [1:0]       n_alloc;
   logic [1:0]       n_retire;
   logic [PW-1:0]    head_next;
   logic [PW-1:0]    tail_next;
   logic [PW-1:0]    count_next;
   logic [PW-1:0]    mp_pos;
   logic [PTR_W-1:0] rd_ptr;
   logic [31:0]      rd_top;

   // Requiring two free slots means a dual request is never split.
   assign alloc_ready = ~reset & (state == IDLE) & ~mispredict_valid
                        & (count <= ALLOC_LIMIT);

   assign alloc_tag[0] = tail[TAG_W-1:0];
   assign alloc_tag[1] = tail[TAG_W-1:0] + TAG_W'(1);

   assign wen      = {2{alloc_ready}} & alloc_valid;
   assign n_alloc  = {1'b0, wen[0]} + {1'b0, wen[1]};
   assign n_retire = {1'b0, retire_valid[0]} + {1'b0, retire_valid[1]};

   // Full-width position of the mispredicted entry: it sits in the same lap
   // as head when its index is not below head's index, otherwise one lap on.
   assign mp_pos = (mispredict_tag >= head[TAG_W-1:0])
                   ? {head[TAG_W], mispredict_tag}
                   : {~head[TAG_W], mispredict_tag};

   // Retires still apply in a mispredict cycle; allocation is discarded
   // (alloc_ready is already low) and everything younger than the
   // mispredicted branch is dropped, keeping its own checkpoint.
   assign head_next  = head + PW'(n_retire);
   assign tail_next  = mispredict_valid ? (mp_pos + PW'(1)) : (tail + PW'(n_alloc));
   assign count_next = tail_next - head_next;

   assign free_count  = DEPTH_C - count;
   assign fetch_stall = (state == RESTORE) | mispredict_valid;

   ras_ckpt_mem #(
      .DEPTH (CKPT_DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clock     (clock),
      .wen       (wen),
      .waddr     (alloc_tag),
      .wdata_ptr (ckpt_ptr),
      .wdata_top (ckpt_top),
      .raddr     (mispredict_tag),
      .rdata_ptr (rd_ptr),
      .rdata_top (rd_top)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         state         <= IDLE;
         restore_valid <= 1'b0;
         restore_ptr   <= '0;
         restore_top   <= '0;
      end else begin
         head  <= head_next;
         tail  <= tail_next;
         count <= count_next;
         case (state)
            IDLE, RESTORE: begin
               // A mispredict arriving during a restore re-arms it with the
               // newly read entry, so the strobe stays up another cycle.
               if (mispredict_valid) begin
                  state         <= RESTORE;
                  restore_valid <= 1'b1;
                  restore_ptr   <= rd_ptr;
                  restore_top   <= rd_top;
               end else begin
                  state         <= IDLE;
                  restore_valid <= 1'b0;
               end
            end
            default: begin
               state         <= IDLE;
               restore_valid <= 1'b0;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (PW'(n_retire) <= count)
            else $error("ras_ckpt_ctrl: retire of %0d entries with only %0d live", n_retire, count);
         assert (!(mispredict_valid && (count == '0)))
            else $error("ras_ckpt_ctrl: mispredict with no live checkpoint");
         assert (alloc_valid != 2'b10)
            else $error("ras_ckpt_ctrl: alloc_valid pattern 10 is not supported");
      end
   end
`endif

endmodule : ras_ckpt_ctrl
`default_nettype wire

// File: tb/tb_ras_ckpt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ras_ckpt_ctrl
//  Description : Self-checking bench for ras_ckpt_ctrl. A table of per-cycle
//                vectors carries stimulus and expected combinational outputs;
//                expected restore payloads go into a queue when a mispredict
//                is driven and are popped when restore_valid appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ras_ckpt_ctrl;
   import ras_pkg::*;

   logic            clock;
   logic            reset;
   logic [1:0]      alloc_valid;
   logic [1:0][2:0] ckpt_ptr;
   logic [1:0][31:0] ckpt_top;
   logic            alloc_ready;
   logic [1:0][3:0] alloc_tag;
   logic [1:0]      retire_valid;
   logic            mispredict_valid;
   logic [3:0]      mispredict_tag;
   logic            restore_valid;
   logic [2:0]      restore_ptr;
   logic [31:0]     restore_top;
   logic            fetch_stall;
   logic [4:0]      free_count;

   ras_ckpt_ctrl #(.STACK_SIZE(8), .CKPT_DEPTH(16)) dut (
      .clock            (clock),
      .reset            (reset),
      .alloc_valid      (alloc_valid),
      .ckpt_ptr         (ckpt_ptr),
      .ckpt_top         (ckpt_top),
      .alloc_ready      (alloc_ready),
      .alloc_tag        (alloc_tag),
      .retire_valid     (retire_valid),
      .mispredict_valid (mispredict_valid),
      .mispredict_tag   (mispredict_tag),
      .restore_valid    (restore_valid),
      .restore_ptr      (restore_ptr),
      .restore_top      (restore_top),
      .fetch_stall      (fetch_stall),
      .free_count       (free_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      bit          rst;
      logic [1:0]  av;
      logic [2:0]  p0, p1;
      logic [31:0] t0, t1;
      logic [1:0]  rv;
      logic        mv;
      logic [3:0]  mt;
      logic        e_ready;
      logic [3:0]  e_tag0;
      logic [4:0]  e_free;
      logic        e_stall;
      logic        e_rv;
      logic        push;
      logic [2:0]  r_ptr;
      logic [31:0] r_top;
   } vec_t;

   vec_t      tbl[$];
   ras_ckpt_t exp_q[$];
   ras_ckpt_t sb_e;
   int        n_checks = 0;
   int        n_fail   = 0;

   function automatic vec_t mk(bit rst, logic [1:0] av, logic [2:0] p0, logic [2:0] p1,
                               logic [31:0] t0, logic [31:0] t1, logic [1:0] rv,
                               logic mv, logic [3:0] mt, logic e_ready, logic [3:0] e_tag0,
                               logic [4:0] e_free, logic e_stall, logic e_rv,
                               logic push, logic [2:0] r_ptr, logic [31:0] r_top);
      vec_t v;
      v.rst = rst; v.av = av; v.p0 = p0; v.p1 = p1; v.t0 = t0; v.t1 = t1;
      v.rv = rv; v.mv = mv; v.mt = mt; v.e_ready = e_ready; v.e_tag0 = e_tag0;
      v.e_free = e_free; v.e_stall = e_stall; v.e_rv = e_rv;
      v.push = push; v.r_ptr = r_ptr; v.r_top = r_top;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Tags 0..5 with ptr = i, top = 0x1000 + 4i, starting from an empty buffer.
   task automatic add_alloc_0_to_5();
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(0, 2'b11, 3'(2*k), 3'(2*k+1), 32'(32'h1000 + 8*k),
                          32'(32'h1004 + 8*k), 2'b00, 0, 0, 1, 4'(2*k), 5'(16 - 2*k),
                          0, 0, 0, 0, 0));
   endtask

   task automatic apply(input int idx, input vec_t v);
      reset            = v.rst;
      alloc_valid      = v.av;
      ckpt_ptr[0]      = v.p0;
      ckpt_ptr[1]      = v.p1;
      ckpt_top[0]      = v.t0;
      ckpt_top[1]      = v.t1;
      retire_valid     = v.rv;
      mispredict_valid = v.mv;
      mispredict_tag   = v.mt;
      if (v.push) exp_q.push_back('{ptr: v.r_ptr, top: v.r_top});
      #2;
      chk($sformatf("v%0d alloc_ready", idx), alloc_ready, v.e_ready);
      if (v.e_ready) begin
         chk($sformatf("v%0d alloc_tag0", idx), alloc_tag[0], v.e_tag0);
         chk($sformatf("v%0d alloc_tag1", idx), alloc_tag[1], 4'(v.e_tag0 + 4'd1));
      end
      chk($sformatf("v%0d free_count", idx), free_count, v.e_free);
      chk($sformatf("v%0d fetch_stall", idx), fetch_stall, v.e_stall);
      chk($sformatf("v%0d restore_valid", idx), restore_valid, v.e_rv);
      @(posedge clock);
      #1;
   endtask

   // Restore payload scoreboard.
   always @(negedge clock) begin
      if (restore_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL restore_unexpected: got restore_ptr %0h, expected no restore", restore_ptr);
         end else begin
            sb_e = exp_q.pop_front();
            chk("restore_ptr", restore_ptr, sb_e.ptr);
            chk("restore_top", restore_top, sb_e.top);
         end
      end
   end

   initial begin
      // ---- Seq A: first allocation, fill to full, retire re-opens ----
      tbl.push_back(mk(0, 2'b11, 3, 4, 32'hA0, 32'hA1, 2'b00, 0, 0, 1, 0, 16, 0, 0, 0, 0, 0));
      for (int k = 1; k < 8; k++)
         tbl.push_back(mk(0, 2'b11, 3'(k), 3'(k), 32'(k), 32'(k), 2'b00, 0, 0,
                          1, 4'(2*k), 5'(16 - 2*k), 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b11, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0));
      // ---- Seq B: mispredict tag 2, allocation resumes at tag 3 ----
      tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
      add_alloc_0_to_5();
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2, 0, 0, 10, 1, 0, 1, 2, 32'h1008));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 13, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 2'b11, 6, 7, 32'h2000, 32'h2004, 2'b00, 0, 0, 1, 3, 13, 0, 0, 0, 0, 0));
      // ---- Seq C: mispredict tag 4 with retire 11 and a dropped allocation ----
      tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 11, 0, 0, 0, 0, 0));
      add_alloc_0_to_5();
      tbl.push_back(mk(0, 2'b11, 1, 1, 0, 0, 2'b11, 1, 4, 0, 0, 10, 1, 0, 1, 4, 32'h1010));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 13, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 2'b11, 5, 6, 32'h3000, 32'h3004, 2'b00, 0, 0, 1, 5, 13, 0, 0, 0, 0, 0));
      // ---- Seq D: back-to-back mispredicts, tag 5 then tag 1 ----
      tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 11, 0, 0, 0, 0, 0));
      add_alloc_0_to_5();
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 5, 0, 0, 10, 1, 0, 1, 5, 32'h1014));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 10, 1, 1, 1, 1, 32'h1004));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 14, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 2'b11, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2, 14, 0, 0, 0, 0, 0));
      // ---- Seq E: wrap-around, mispredict across the wrap, reset in RESTORE ----
      tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0));
      for (int i = 0; i < 63; i++)
         tbl.push_back(mk(0, 2'b01, 3'(i % 8), 0, 32'(32'h4000 + i), 0,
                          (i > 0) ? 2'b01 : 2'b00, 0, 0, 1, 4'(i % 16),
                          (i == 0) ? 5'd16 : 5'd15, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b11, 1, 2, 32'h5000, 32'h5001, 2'b00, 0, 0, 1, 15, 15, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 15, 0, 0, 13, 1, 0, 1, 1, 32'h5000));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 14, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 2'b11, 3, 4, 32'h6000, 32'h6004, 2'b00, 0, 0, 1, 0, 14, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 12, 1, 0, 1, 3, 32'h6000));
      tbl.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 1, 14, 0, 0, 13, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 16, 0, 0, 0, 0, 0));

      // ---- Reset state ----
      reset            = 1'b1;
      alloc_valid      = '0;
      ckpt_ptr         = '0;
      ckpt_top         = '0;
      retire_valid     = '0;
      mispredict_valid = 1'b0;
      mispredict_tag   = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset alloc_ready_low", alloc_ready, 1'b0);
      reset = 1'b0;
      #2;
      chk("reset restore_valid", restore_valid, 1'b0);
      chk("reset restore_ptr", restore_ptr, 3'd0);
      chk("reset restore_top", restore_top, 32'd0);
      chk("reset fetch_stall", fetch_stall, 1'b0);
      chk("reset free_count", free_count, 5'd16);
      chk("reset alloc_ready", alloc_ready, 1'b1);
      chk("reset alloc_tag0", alloc_tag[0], 4'd0);
      @(posedge clock);
      #1;

      for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

      reset            = 1'b0;
      alloc_valid      = '0;
      retire_valid     = '0;
      mispredict_valid = 1'b0;
      #2;
      chk("post restore_valid", restore_valid, 1'b0);
      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_ras_ckpt_ctrl
`default_nettype wire
